// File: rtl/char_terminal_ctrl_if.sv
// Host character handshake of the terminal: 7-bit ASCII with da / rda_n.
// The host (master) raises da with rd; the terminal (slave) acks with rda_n.
interface char_terminal_ctrl_if;
  logic [7:1] rd;
  logic       da;
  logic       rda_n;

  modport master (output rd, output da, input rda_n);
  modport slave  (input rd, input da, output rda_n);
endinterface

// File: rtl/char_terminal_ctrl.sv
// Character terminal controller: places incoming ASCII into a circular COLS x ROWS
// character buffer, and feeds a registered scan port with a blinking cursor overlay.
module char_terminal_ctrl #(
  parameter int unsigned  COLS      = 40,
  parameter int unsigned  ROWS      = 24,
  parameter int unsigned  BLINK_DIV = 12500000,
  parameter int unsigned  BS_EN     = 1,
  localparam int unsigned CW        = $clog2(COLS),
  localparam int unsigned RW        = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                mr_n,
  char_terminal_ctrl_if.slave host,
  input  logic                clr,
  input  logic [RW-1:0]       scan_row,
  input  logic [CW-1:0]       scan_col,
  output logic [5:0]          scan_char,
  output logic                scan_cursor,
  output logic [RW-1:0]       cur_row,
  output logic [CW-1:0]       cur_col,
  output logic                busy
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = $clog2(BLINK_DIV);
  localparam int unsigned RW1   = RW + 1;
  localparam int unsigned CW1   = CW + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [5:0]    SPACE    = 6'h20;

  typedef enum logic [2:0] {IDLE, EXEC, CLEAR_ROW, CLEAR_ALL, WAIT_DA_LOW} state_e;

  state_e        state_q, state_d;
  logic          rda_n_q, rda_n_d;
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [CW-1:0] cur_col_q, cur_col_d;
  logic [RW-1:0] top_q, top_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] clr_col_q, clr_col_d;
  logic [7:1]    ch_q, ch_d;
  logic          busy_q;
  logic          blink_q;
  logic [BW-1:0] blink_cnt_q;
  logic [5:0]    scan_char_q;
  logic          scan_cursor_q;

  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [5:0]    wdata_c;
  logic          printable_c, cr_c, bs_c, newline_c, last_cell_c, scan_ok_c;

  logic [5:0]    mem [DEPTH];

  // Logical row to physical row through the circular top pointer.
  function automatic logic [RW-1:0] phys(input logic [RW-1:0] row, input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= RW1'(ROWS)) sum = sum - RW1'(ROWS);
    return sum[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] prow, input logic [CW-1:0] col);
    return AW'(prow) * COLS_A + AW'(col);
  endfunction

  assign printable_c = ch_q[7] | ch_q[6];
  assign cr_c        = (ch_q == 7'h0D);
  assign bs_c        = (BS_EN != 0) && (ch_q == 7'h08);
  assign newline_c   = (printable_c && (cur_col_q == COL_LAST)) || cr_c;
  assign last_cell_c = (clr_row_q == ROW_LAST) && (clr_col_q == COL_LAST);
  assign scan_ok_c   = ({1'b0, scan_row} < RW1'(ROWS)) && ({1'b0, scan_col} < CW1'(COLS));

  // State register.
  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) state_q <= CLEAR_ALL;
    else       state_q <= state_d;
  end

  // Next-state logic; clr preempts everything, including a running clear.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = CLEAR_ALL;
    end else begin
      case (state_q)
        IDLE:        if (host.da) state_d = EXEC;
        EXEC:        state_d = (newline_c && (cur_row_q == ROW_LAST)) ? CLEAR_ROW : WAIT_DA_LOW;
        CLEAR_ROW:   if (clr_col_q == COL_LAST) state_d = WAIT_DA_LOW;
        CLEAR_ALL:   if (last_cell_c) state_d = rda_n_q ? IDLE : WAIT_DA_LOW;
        WAIT_DA_LOW: if (!host.da) state_d = IDLE;
        default:     state_d = CLEAR_ALL;
      endcase
    end
  end

  // Datapath next values and buffer write port.
  always_comb begin
    rda_n_d   = rda_n_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    top_d     = top_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    ch_d      = ch_q;
    we_c      = 1'b0;
    waddr_c   = addr_of(phys(cur_row_q, top_q), cur_col_q);
    wdata_c   = ch_q[6:1];
    if (clr) begin
      clr_row_d = '0;
      clr_col_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.da) begin
            ch_d    = host.rd;
            rda_n_d = 1'b0;
          end
        end
        EXEC: begin
          if (printable_c) begin
            we_c = 1'b1;
            if (cur_col_q != COL_LAST) cur_col_d = cur_col_q + CW'(1);
          end
          if (newline_c) begin
            cur_col_d = '0;
            if (cur_row_q != ROW_LAST) begin
              cur_row_d = cur_row_q + RW'(1);
            end else begin
              top_d     = (top_q == ROW_LAST) ? '0 : top_q + RW'(1);
              clr_col_d = '0;
            end
          end
          if (bs_c) begin
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - CW'(1);
            end else if (cur_row_q != '0) begin
              cur_row_d = cur_row_q - RW'(1);
              cur_col_d = COL_LAST;
            end
          end
        end
        CLEAR_ROW: begin
          // top_q already points past the scrolled-out row, so ROW_LAST is the fresh bottom row.
          we_c      = 1'b1;
          waddr_c   = addr_of(phys(ROW_LAST, top_q), clr_col_q);
          wdata_c   = SPACE;
          clr_col_d = (clr_col_q == COL_LAST) ? '0 : clr_col_q + CW'(1);
        end
        CLEAR_ALL: begin
          we_c    = 1'b1;
          waddr_c = addr_of(clr_row_q, clr_col_q);
          wdata_c = SPACE;
          if (clr_col_q == COL_LAST) begin
            clr_col_d = '0;
            clr_row_d = (clr_row_q == ROW_LAST) ? '0 : clr_row_q + RW'(1);
          end else begin
            clr_col_d = clr_col_q + CW'(1);
          end
          if (last_cell_c) begin
            cur_row_d = '0;
            cur_col_d = '0;
            top_d     = '0;
          end
        end
        WAIT_DA_LOW: if (!host.da) rda_n_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      rda_n_q       <= 1'b1;
      cur_row_q     <= '0;
      cur_col_q     <= '0;
      top_q         <= '0;
      clr_row_q     <= '0;
      clr_col_q     <= '0;
      ch_q          <= '0;
      busy_q        <= 1'b1;
      blink_q       <= 1'b0;
      blink_cnt_q   <= '0;
      scan_char_q   <= '0;
      scan_cursor_q <= 1'b0;
    end else begin
      rda_n_q       <= rda_n_d;
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      top_q         <= top_d;
      clr_row_q     <= clr_row_d;
      clr_col_q     <= clr_col_d;
      ch_q          <= ch_d;
      busy_q        <= (state_d == CLEAR_ROW) || (state_d == CLEAR_ALL);
      blink_cnt_q   <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
      if (blink_cnt_q == BLINK_LAST) blink_q <= ~blink_q;
      scan_char_q   <= scan_ok_c ? mem[addr_of(phys(scan_row, top_q), scan_col)] : '0;
      scan_cursor_q <= blink_q & ~busy_q & (scan_row == cur_row_q) & (scan_col == cur_col_q);
    end
  end

  // Character buffer: single write port, scan read sees pre-write data.
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= wdata_c;
  end

  assign host.rda_n  = rda_n_q;
  assign scan_char   = scan_char_q;
  assign scan_cursor = scan_cursor_q;
  assign cur_row     = cur_row_q;
  assign cur_col     = cur_col_q;
  assign busy        = busy_q;

endmodule
